// File: rtl/isqrt_csr_pkg.sv
// isqrt_csr_pkg: shared definitions for the square-root CSR slave.
//   - register offsets inside the 32-byte decode window
//   - CTRL / STATUS bit positions
//   - core FSM state type
package isqrt_csr_pkg;

    localparam int ISQRT_ITER = 16;

    localparam logic [4:0] OFS_OPERAND = 5'h00;
    localparam logic [4:0] OFS_CTRL    = 5'h04;
    localparam logic [4:0] OFS_STATUS  = 5'h08;
    localparam logic [4:0] OFS_ROOT    = 5'h0C;
    localparam logic [4:0] OFS_REM     = 5'h10;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_CLR_OVR  = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVR  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

endpackage

// File: rtl/isqrt_core.sv
// isqrt_core: iterative restoring square root, one root bit per cycle.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   start_i           start request (ignored unless idle)
//   operand_bi[31:0]  radicand, sampled when a start is taken
//   busy_o            high while iterating
//   done_o            1-cycle pulse during the final iteration cycle;
//                     root_bo/rem_bo hold the new result after that edge
//   root_bo[15:0]     last completed root
//   rem_bo[16:0]      last completed remainder
module isqrt_core
    import isqrt_csr_pkg::*;
#(
    parameter int ITER = ISQRT_ITER
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] operand_bi,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] root_bo,
    output logic [16:0] rem_bo
);

    localparam int CW = $clog2(ITER);

    state_e         state_q, state_d;
    logic [31:0]    work_q;
    logic [15:0]    proot_q;
    logic [16:0]    prem_q;
    logic [CW-1:0]  cnt_q;

    logic [18:0]    rem_sh;
    logic [18:0]    trial_sub;
    logic [18:0]    trial;
    logic           take;
    logic [15:0]    root_nx;
    logic [16:0]    rem_nx;
    logic           last;

    // One digit step: bring down two radicand bits, trial-subtract 4r+1.
    // The partial remainder never exceeds 2r, so 17 bits hold it whether or
    // not the subtraction is taken.
    always_comb begin
        rem_sh    = {prem_q, work_q[31:30]};
        trial_sub = {1'b0, proot_q, 2'b01};
        trial     = rem_sh - trial_sub;
        take      = (rem_sh >= trial_sub);
        root_nx   = {proot_q[14:0], take};
        rem_nx    = take ? trial[16:0] : rem_sh[16:0];
    end

    assign last   = (cnt_q == CW'(ITER - 1));
    assign busy_o = (state_q == CALC);

    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        case (state_q)
            IDLE: if (start_i) state_d = CALC;
            CALC: begin
                if (last) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            proot_q <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            root_bo <= '0;
            rem_bo  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        work_q  <= operand_bi;
                        proot_q <= '0;
                        prem_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    work_q  <= {work_q[29:0], 2'b00};
                    proot_q <= root_nx;
                    prem_q  <= rem_nx;
                    cnt_q   <= cnt_q + 1'b1;
                    // Result registers only move on completion so the host
                    // keeps seeing the previous answer while a new one runs.
                    if (last) begin
                        root_bo <= root_nx;
                        rem_bo  <= rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/isqrt_csr_slave.sv
// isqrt_csr_slave: UDM split-bus slave wrapping isqrt_core.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   bus_req_i/we_i/addr_bi/be_bi/wdata_bi   bus request side
//   bus_ack_o                    combinational accept (always ready on hit)
//   bus_resp_o, bus_rdata_bo     read response, one cycle after accept
//   irq_o                        level interrupt = STATUS.done
module isqrt_csr_slave
    import isqrt_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h80001000,
    parameter int          ITER      = ISQRT_ITER
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        irq_o
);

    logic        hit, wr_acc, rd_acc;
    logic [4:0]  ofs;
    logic        ctrl_wr, cmd_start, cmd_clr_done, cmd_clr_ovr;

    logic [31:0] operand_q;
    logic        done_q, ovr_q;
    logic        resp_q;
    logic [4:0]  raddr_q;

    logic        core_busy, core_done;
    logic [15:0] core_root;
    logic [16:0] core_rem;

    assign hit       = (bus_addr_bi[31:5] == BASE_ADDR[31:5]);
    assign bus_ack_o = bus_req_i & hit;
    assign wr_acc    = bus_ack_o & bus_we_i;
    assign rd_acc    = bus_ack_o & ~bus_we_i;
    assign ofs       = bus_addr_bi[4:0];

    assign ctrl_wr      = wr_acc && (ofs == OFS_CTRL) && bus_be_bi[0];
    assign cmd_start    = ctrl_wr & bus_wdata_bi[CTRL_START];
    assign cmd_clr_done = ctrl_wr & bus_wdata_bi[CTRL_CLR_DONE];
    assign cmd_clr_ovr  = ctrl_wr & bus_wdata_bi[CTRL_CLR_OVR];

    isqrt_core #(.ITER(ITER)) u_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (cmd_start),
        .operand_bi (operand_q),
        .busy_o     (core_busy),
        .done_o     (core_done),
        .root_bo    (core_root),
        .rem_bo     (core_rem)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            operand_q <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            resp_q    <= 1'b0;
            raddr_q   <= '0;
        end else begin
            if (wr_acc && (ofs == OFS_OPERAND)) begin
                for (int b = 0; b < 4; b++)
                    if (bus_be_bi[b]) operand_q[8*b +: 8] <= bus_wdata_bi[8*b +: 8];
            end

            // Completion outranks a simultaneous clear so a result is never lost.
            if (core_done)         done_q <= 1'b1;
            else if (cmd_clr_done) done_q <= 1'b0;

            if (cmd_start && core_busy) ovr_q <= 1'b1;
            else if (cmd_clr_ovr)       ovr_q <= 1'b0;

            resp_q  <= rd_acc;
            raddr_q <= ofs;
        end
    end

    // Read data is muxed from live registers during the response cycle, so a
    // read accepted on the completion edge already sees done/ROOT/REM.
    always_comb begin
        bus_rdata_bo = '0;
        if (resp_q) begin
            case (raddr_q)
                OFS_OPERAND: bus_rdata_bo = operand_q;
                OFS_STATUS:  bus_rdata_bo = {29'd0, ovr_q, done_q, core_busy};
                OFS_ROOT:    bus_rdata_bo = {16'd0, core_root};
                OFS_REM:     bus_rdata_bo = {15'd0, core_rem};
                default:     bus_rdata_bo = '0;
            endcase
        end
    end

    assign bus_resp_o = resp_q;
    assign irq_o      = done_q;

endmodule

// File: tb/tb_isqrt_csr_slave.sv
module tb_isqrt_csr_slave;

    localparam logic [31:0] BASE = 32'h80001000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_req_i = 1'b0;
    logic        bus_we_i = 1'b0;
    logic [31:0] bus_addr_bi = '0;
    logic [3:0]  bus_be_bi = '0;
    logic [31:0] bus_wdata_bi = '0;
    logic        bus_ack_o, bus_resp_o, irq_o;
    logic [31:0] bus_rdata_bo;

    int checks = 0;
    int failures = 0;

    isqrt_csr_slave #(.BASE_ADDR(BASE), .ITER(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus_req_i    (bus_req_i),
        .bus_we_i     (bus_we_i),
        .bus_addr_bi  (bus_addr_bi),
        .bus_be_bi    (bus_be_bi),
        .bus_wdata_bi (bus_wdata_bi),
        .bus_ack_o    (bus_ack_o),
        .bus_resp_o   (bus_resp_o),
        .bus_rdata_bo (bus_rdata_bo),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] op;
        logic [31:0] root;
        logic [31:0] rem;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Reference: greedy bit-by-bit floor sqrt on 64-bit integers.
    function automatic void ref_isqrt(input logic [31:0] op, output logic [31:0] r, output logic [31:0] rm);
        longint unsigned x, s, t;
        x = 64'(op);
        s = 0;
        for (int b = 15; b >= 0; b--) begin
            t = s | (64'd1 << b);
            if (t * t <= x) s = t;
        end
        r  = 32'(s);
        rm = 32'(x - s * s);
    endfunction

    task automatic wr(input logic [4:0] ofs, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk_i);
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = BASE + 32'(ofs);
        bus_be_bi = be; bus_wdata_bi = d;
        @(posedge clk_i);
        #1 bus_req_i = 1'b0; bus_we_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] ofs, output logic resp, output logic [31:0] d);
        @(negedge clk_i);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = BASE + 32'(ofs);
        @(posedge clk_i);
        #1 bus_req_i = 1'b0;
        @(negedge clk_i);
        resp = bus_resp_o;
        d    = bus_rdata_bo;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] ofs, input logic [31:0] exp);
        logic        r;
        logic [31:0] d;
        rd(ofs, r, d);
        chk({name, "_resp"}, 32'(r), 32'd1);
        chk(name, d, exp);
    endtask

    // Back-to-back STATUS reads until done; n = reads issued (read n accepted
    // on the n-th edge after the start edge).
    task automatic poll(output int n, output logic [31:0] first);
        n = 0;
        first = '0;
        @(negedge clk_i);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = BASE + 32'h08;
        forever begin
            @(posedge clk_i);
            n++;
            @(negedge clk_i);
            if (n == 1) first = bus_rdata_bo;
            if (bus_resp_o && bus_rdata_bo[1]) break;
            if (n >= 100) begin
                chk("poll_timeout", 32'(n), 32'd16);
                break;
            end
        end
        bus_req_i = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [31:0] op,
                           input logic [31:0] er, input logic [31:0] em);
        int          n;
        logic [31:0] first;
        wr(5'h00, op, 4'hF);
        wr(5'h04, 32'h3, 4'h1);
        poll(n, first);
        chk({name, "_first_status"}, first, 32'h1);
        chk({name, "_latency"}, 32'(n), 32'd16);
        chk({name, "_irq"}, 32'(irq_o), 32'd1);
        rd_chk({name, "_root"}, 5'h0C, er);
        rd_chk({name, "_rem"}, 5'h10, em);
    endtask

    initial begin
        logic [31:0] er, em, op, d;
        logic        r;
        int          n;

        vecs[0] = '{32'd1000000,  32'h3E8,  32'h0};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFF, 32'h1FFFE};
        vecs[2] = '{32'h80000000, 32'hB504, 32'h157F0};
        vecs[3] = '{32'd0,        32'h0,    32'h0};
        vecs[4] = '{32'd1,        32'h1,    32'h0};
        vecs[5] = '{32'd3,        32'h1,    32'h2};
        vecs[6] = '{32'd24,       32'h4,    32'h8};

        // Reset state
        #12;
        chk("rst_resp", 32'(bus_resp_o), 32'd0);
        chk("rst_rdata", bus_rdata_bo, 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        @(negedge clk_i); rst_i = 1'b0;
        rd_chk("rst_operand", 5'h00, 32'h0);
        rd_chk("rst_status", 5'h08, 32'h0);
        rd_chk("rst_root", 5'h0C, 32'h0);
        rd_chk("rst_rem", 5'h10, 32'h0);

        // Directed table
        for (int i = 0; i < 7; i++)
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].root, vecs[i].rem);

        // Clear done drops the interrupt; RO writes ignored; CTRL reads 0
        wr(5'h04, 32'h2, 4'h1);
        chk("clr_done_irq", 32'(irq_o), 32'd0);
        wr(5'h0C, 32'hFFFFFFFF, 4'hF);
        rd_chk("ro_root_kept", 5'h0C, 32'h4);
        rd_chk("ctrl_reads_0", 5'h04, 32'h0);

        // Byte enables, unused offset, out-of-window
        wr(5'h00, 32'h0, 4'hF);
        wr(5'h00, 32'hAABBCCDD, 4'b0010);
        rd_chk("be_operand", 5'h00, 32'h0000CC00);
        rd_chk("ofs18", 5'h18, 32'h0);
        @(negedge clk_i);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = BASE + 32'h20;
        #1 chk("oow_ack", 32'(bus_ack_o), 32'd0);
        @(posedge clk_i);
        #1 bus_req_i = 1'b0;
        @(negedge clk_i);
        chk("oow_resp", 32'(bus_resp_o), 32'd0);

        // Start while busy: overrun, result from the snapshot
        wr(5'h00, 32'd1000000, 4'hF);
        wr(5'h04, 32'h3, 4'h1);
        repeat (4) @(posedge clk_i);
        wr(5'h00, 32'd4, 4'hF);
        wr(5'h04, 32'h1, 4'h1);
        poll(n, d);
        rd_chk("ovr_root", 5'h0C, 32'h3E8);
        rd_chk("ovr_status", 5'h08, 32'h6);
        rd_chk("ovr_operand", 5'h00, 32'd4);
        wr(5'h04, 32'h4, 4'h1);
        rd_chk("clr_ovr_status", 5'h08, 32'h2);

        // Reset mid-computation
        wr(5'h00, 32'd50000, 4'hF);
        wr(5'h04, 32'h3, 4'h1);
        repeat (8) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("midrst_resp", 32'(bus_resp_o), 32'd0);
        chk("midrst_irq", 32'(irq_o), 32'd0);
        chk("midrst_rdata", bus_rdata_bo, 32'd0);
        @(negedge clk_i); @(negedge clk_i); rst_i = 1'b0;
        rd_chk("midrst_status", 5'h08, 32'h0);
        rd_chk("midrst_root", 5'h0C, 32'h0);
        run_one("after_rst", 32'd144, 32'd12, 32'd0);

        // Random operands against the reference model
        for (int i = 0; i < 12; i++) begin
            op = $urandom;
            if (i == 0) op = 32'hFFFE0001;  // (2^16-1)^2: exact square at the top
            ref_isqrt(op, er, em);
            run_one($sformatf("rnd%0d_%08h", i, op), op, er, em);
        end

        rd(5'h08, r, d);
        chk("final_resp", 32'(r), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
